// File: rtl/fetch_unit_pkg.sv
// Shared pipeline defines for the fetch stage: state encodings, bubble IR, PC helper.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_IR = 16'h0000;

  // Word-addressed; wraps silently at the top of the address space.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_buf.sv
// One-entry hold buffer for a word that arrived while decode was stalled.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_ir,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_ir
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ir    <= NOP_IR;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_ir    <= i_ir;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_ir    = r_ir;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, stall via hold buffer, redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        toPipe1Valid,
  output logic [15:0] toPipe1PC,
  output logic [15:0] toPipe1IR
);

  fetch_state_t r_state, w_state_nxt;
  logic [15:0]  r_pc, r_target, w_pc_nxt, w_target_nxt;
  logic         r_valid;
  logic [15:0]  r_p1_pc, r_p1_ir;
  logic         w_from_mem, w_from_buf, w_bubble, w_buf_load, w_buf_clear;
  logic         w_buf_valid;
  logic [15:0]  w_buf_pc, w_buf_ir;

  fetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_ir    (imem_data),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_ir    (w_buf_ir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FETCH: begin
        if (redirect)              w_state_nxt = imem_ack ? ST_FETCH : ST_FLUSH;
        else if (imem_ack && stall) w_state_nxt = ST_HOLD;
      end
      ST_HOLD:  if (redirect || !stall) w_state_nxt = ST_FETCH;
      ST_FLUSH: if (imem_ack) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req     = (r_state != ST_HOLD);
    w_pc_nxt     = r_pc;
    w_target_nxt = r_target;
    w_from_mem   = 1'b0;
    w_from_buf   = 1'b0;
    w_bubble     = 1'b0;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (redirect) begin
          w_bubble    = 1'b1;
          w_buf_clear = 1'b1;
          if (imem_ack) w_pc_nxt     = redirect_pc;
          else          w_target_nxt = redirect_pc;
        end else if (imem_ack && !stall) begin
          w_from_mem = 1'b1;
          w_pc_nxt   = next_pc(r_pc);
        end else if (imem_ack) begin
          w_buf_load = 1'b1;
        end else if (!stall) begin
          w_bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          w_bubble    = 1'b1;
          w_buf_clear = 1'b1;
          w_pc_nxt    = redirect_pc;
        end else if (!stall) begin
          w_from_buf  = 1'b1;
          w_buf_clear = 1'b1;
          w_pc_nxt    = next_pc(w_buf_pc);
        end
      end
      ST_FLUSH: begin
        // The old-address request stays up until its ack; that word is dropped.
        if (redirect) begin
          w_bubble     = 1'b1;
          w_target_nxt = redirect_pc;
          if (imem_ack) w_pc_nxt = redirect_pc;
        end else if (imem_ack) begin
          w_pc_nxt = r_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_target <= '0;
      r_valid  <= 1'b0;
      r_p1_pc  <= '0;
      r_p1_ir  <= NOP_IR;
    end else begin
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
      if (w_from_mem) begin
        r_valid <= 1'b1;
        r_p1_pc <= r_pc;
        r_p1_ir <= imem_data;
      end else if (w_from_buf) begin
        r_valid <= w_buf_valid;
        r_p1_pc <= w_buf_pc;
        r_p1_ir <= w_buf_ir;
      end else if (w_bubble) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign toPipe1Valid = r_valid;
  assign toPipe1PC    = r_p1_pc;
  assign toPipe1IR    = r_p1_ir;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req  out  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  out  16  word address of request.
REQ-006 SHALL have port imem_ack  in  1  memory response valid; sampled at rising edge while imem_req=1.
REQ-007 SHALL have port imem_data  in  16  instruction word, valid with imem_ack.
REQ-008 SHALL have port stall  in  1  pipe1 consumer (decode) cannot accept; hold pipe1.
REQ-009 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  in  16  target address, valid with redirect.
REQ-011 SHALL have port toPipe1Valid  out  1  pipe1 holds a live instruction.
REQ-012 SHALL have port toPipe1PC  out  16  PC of the pipe1 instruction.
REQ-013 SHALL have port toPipe1IR  out  16  pipe1 instruction word.

Function
REQ-014 SHALL implement states FETCH (request outstanding), HOLD (word captured, pipe1 stalled), FLUSH (discarding in-flight response).
REQ-015 SHALL assert imem_req in FETCH and FLUSH only; imem_addr SHALL stay constant from assertion until the ack edge.
REQ-016 SHALL address words; next PC = PC + 1, modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
REQ-017 FETCH, ack=1, stall=0, redirect=0: pipe1 <= {1, addr, imem_data} at that edge; next request to addr+1 in the following cycle (one instruction per cycle at zero wait).
REQ-018 FETCH, ack=1, stall=1: word and its PC captured in the hold buffer; pipe1 unchanged; go to HOLD; imem_req=0.
REQ-019 HOLD, stall=0: pipe1 <= hold buffer; go to FETCH at buffer PC+1.
REQ-020 stall=1, no redirect: toPipe1Valid/PC/IR SHALL not change.
REQ-021 FETCH, ack=0, stall=0: toPipe1Valid <= 0 (bubble).
REQ-022 redirect=1 SHALL override stall and all else: toPipe1Valid <= 0, hold buffer discarded, next fetch address = redirect_pc.
REQ-023 redirect in FETCH with ack=0: go to FLUSH; in-flight request kept at old address until ack; that ack's data SHALL be discarded; then FETCH at redirect_pc.
REQ-024 redirect in FETCH with ack=1 same edge: data discarded; FETCH at redirect_pc next cycle.
REQ-025 redirect in HOLD: go to FETCH at redirect_pc.
REQ-026 redirect in FLUSH: latest redirect_pc replaces stored target; stay in FLUSH until ack.
REQ-027 SHALL never present the same fetched word to pipe1 twice nor drop a non-flushed word.

Reset
REQ-028 Reset assertion SHALL immediately force state FETCH, fetch address RESET_PC, toPipe1Valid=0, toPipe1PC=0, toPipe1IR=0, hold buffer empty.
REQ-029 imem_req SHALL be 1 with imem_addr=RESET_PC while reset is asserted and after deassertion; any response pending across reset is the memory's responsibility to abandon.
REQ-030 Reset mid-FLUSH or mid-HOLD SHALL discard stored target and buffered word.

Structure
REQ-031 State encodings and the NOP/bubble IR value (16'h0000) SHALL live in the shared pipeline defines header.
REQ-032 The one-entry hold buffer SHALL be sub-module fetch_buf (load, clear, valid, pc, ir); the rest stays in fetch_unit.

Verification
REQ-033 Reset, zero-wait memory returning addr as data, stall=0 -> pipe1 shows (0,0),(1,1),(2,2) on consecutive cycles.
REQ-034 Ack for addr 5 with stall=1 for 3 cycles -> pipe1 unchanged, imem_req=0; on release pipe1=(5,mem[5]), next imem_addr=6.
REQ-035 Memory with 2-cycle latency, redirect to 16'h0040 one cycle after request to 9 -> addr 9 held until ack, its data never in pipe1, next imem_addr=16'h0040, toPipe1Valid=0 meanwhile.
REQ-036 redirect to 16'h0100 coincident with ack and stall=1 -> toPipe1Valid=0, no HOLD entry, next imem_addr=16'h0100.
REQ-037 Fetch from 16'hFFFF, ack -> next imem_addr=16'h0000.
REQ-038 Assert reset during HOLD -> outputs zero immediately, imem_addr=RESET_PC, buffered word never appears.
